// File: rtl/soc_system_clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
package soc_system_clkgen_pkg;

    // Top-level sequencing states.
    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_APPLY  = 2'd2
    } clkgen_state_e;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_DIV_W       = 16;
    localparam int unsigned DEF_DIV         = 2;
    localparam int unsigned DEF_LOCK_CYCLES = 256;

    // Counter start value on restart: the phase clamped into [0, div-1]; a disabled channel (div 0) sits at 0.
    function automatic int unsigned restart_cnt(input int unsigned div, input int unsigned phase);
        if (div == 0) begin
            return 0;
        end
        return (phase > div - 1) ? div - 1 : phase;
    endfunction

endpackage

// File: rtl/soc_system_clkgen_ch.sv
// One divider channel: divide/phase registers, wrapping counter and registered clock/strobe outputs.
// Outputs are computed from the counter value of the previous cycle, so a restart only shows on the pins one edge later.
module soc_system_clkgen_ch
    import soc_system_clkgen_pkg::*;
#(
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             restart_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic [DIV_W-1:0] wr_phase_i,
    output logic             outclk_o,
    output logic             en_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             outclk_q, outclk_d;
    logic             en_q, en_d;

    // Next-state: config capture, counter wrap/restart and output decode.
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (wr_en_i) begin
            div_d   = wr_div_i;
            phase_d = wr_phase_i;
        end

        if (restart_i) begin
            cnt_d = DIV_W'(restart_cnt(32'(div_d), 32'(phase_d)));
        end else if ((div_q == '0) || (cnt_q == div_q - 1'b1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // High for floor(D/2) counts; D of 0 or 1 never satisfies this.
        outclk_d = (cnt_q < (div_q >> 1));
        en_d     = (div_q != '0) && (cnt_q == div_q - 1'b1);
    end

    // Channel registers with synchronous reset to the default ratio.
    always_ff @(posedge refclk) begin
        if (rst) begin
            div_q    <= DIV_W'(DEFAULT_DIV);
            phase_q  <= '0;
            cnt_q    <= '0;
            outclk_q <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            outclk_q <= outclk_d;
            en_q     <= en_d;
        end
    end

    assign outclk_o = outclk_q;
    assign en_o     = en_q;

endmodule

// File: rtl/soc_system_clkgen.sv
// Multi-channel clock generator top: config handshake, settle/lock sequencing and strobe gating.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_SETTLE | outputs running, lock counter counting towards LOCK_CYCLES
//  ST_LOCKED | settled; locked asserted, strobes enabled
//  ST_APPLY  | one cycle: latched config written, every channel restarted
module soc_system_clkgen
    import soc_system_clkgen_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV,
    parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);

    localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    // Field widths track the parameters, so the record lives here rather than in the package.
    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] phase;
    } cfg_t;

    clkgen_state_e    state_q, state_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    cfg_t             cfg_q, cfg_d;
    logic             xfer;
    logic             ch_ok;
    logic             apply;
    logic [NUM_CH-1:0] outclk_raw;
    logic [NUM_CH-1:0] en_raw;

    assign cfg_ready = !rst && (state_q != ST_APPLY);
    assign xfer      = cfg_valid && cfg_ready;
    assign ch_ok     = (32'(cfg_ch) < NUM_CH);
    assign apply     = (state_q == ST_APPLY);

    // Sequencing: accept config, settle, lock.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cfg_d      = cfg_q;
        err_d      = xfer && !ch_ok;

        case (state_q)
            ST_SETTLE: begin
                if (xfer && ch_ok) begin
                    state_d    = ST_APPLY;
                    lock_cnt_d = '0;
                    cfg_d.ch    = cfg_ch;
                    cfg_d.div   = cfg_div;
                    cfg_d.phase = cfg_phase;
                end else if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (xfer && ch_ok) begin
                    state_d    = ST_APPLY;
                    lock_cnt_d = '0;
                    cfg_d.ch    = cfg_ch;
                    cfg_d.div   = cfg_div;
                    cfg_d.phase = cfg_phase;
                end
            end
            ST_APPLY: begin
                state_d    = ST_SETTLE;
                lock_cnt_d = '0;
            end
            default: begin
                state_d    = ST_SETTLE;
                lock_cnt_d = '0;
            end
        endcase

        // Drops on the edge that accepts a new config, rises one cycle after entering LOCKED.
        locked_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    end

    // Control registers; reset discards any pending config.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= ST_SETTLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            cfg_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            cfg_q      <= cfg_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        soc_system_clkgen_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .refclk     (refclk),
            .rst        (rst),
            .restart_i  (apply),
            .wr_en_i    (apply && (cfg_q.ch == CH_W'(i))),
            .wr_div_i   (cfg_q.div),
            .wr_phase_i (cfg_q.phase),
            .outclk_o   (outclk_raw[i]),
            .en_o       (en_raw[i])
        );
    end

    assign outclk    = outclk_raw;
    assign outclk_en = en_raw & {NUM_CH{locked_q}};
    assign cfg_err   = err_q;
    assign locked    = locked_q;

endmodule
